// File: rtl/router_pkg.sv
// Shared definitions for the mesh router input port: direction codes, header
// field positions, FSM encoding and the per-hop route/rewrite function.
package router_pkg;

  localparam logic [4:0] DIR_L  = 5'b10000;
  localparam logic [4:0] DIR_R  = 5'b01000;
  localparam logic [4:0] DIR_U  = 5'b00100;
  localparam logic [4:0] DIR_D  = 5'b00010;
  localparam logic [4:0] DIR_PE = 5'b00001;

  localparam int HDR_W      = 64;
  localparam int X_SIGN_BIT = 61;
  localparam int Y_SIGN_BIT = 60;
  localparam int XH_LSB     = 48;
  localparam int YH_LSB     = 40;
  localparam int HOP_BITS   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0]       dir;
    logic [HDR_W-1:0] hdr;
  } route_t;

  // force_y selects the Y hop first (detour); without Y hops it falls back to normal XY order.
  function automatic route_t route_calc(input logic [HDR_W-1:0] flit, input logic force_y);
    route_t              r;
    logic [HOP_BITS-1:0] xh;
    logic [HOP_BITS-1:0] yh;
    r.hdr = flit;
    r.dir = DIR_PE;
    xh    = flit[XH_LSB +: HOP_BITS];
    yh    = flit[YH_LSB +: HOP_BITS];
    if (force_y && (yh != '0)) begin
      r.dir                      = flit[Y_SIGN_BIT] ? DIR_D : DIR_U;
      r.hdr[YH_LSB +: HOP_BITS]  = yh - 8'd1;
    end else if (xh != '0) begin
      r.dir                      = flit[X_SIGN_BIT] ? DIR_L : DIR_R;
      r.hdr[XH_LSB +: HOP_BITS]  = xh - 8'd1;
    end else if (yh != '0) begin
      r.dir                      = flit[Y_SIGN_BIT] ? DIR_D : DIR_U;
      r.hdr[YH_LSB +: HOP_BITS]  = yh - 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Flit buffer with head and head+1 visibility so the port can pre-route the
// next entry in the same cycle the current head is popped.
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [DATA_WIDTH-1:0]      head,
  output logic [DATA_WIDTH-1:0]      next,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   ONE_C  = 1;
  localparam logic [AW-1:0] ONE_P  = 1;
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == FULL_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign next    = mem_q[rd_ptr_q + ONE_P];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ONE_P;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ONE_P;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/input_port_adaptive.sv
// Mesh router input port: buffers flits, issues a registered one-hot output
// request with a rewritten hop header, and optionally detours X-stalled flits onto Y.
module input_port_adaptive
  import router_pkg::*;
#(
  parameter int         DATA_WIDTH   = 64,
  parameter int         HOP_W        = 8,
  parameter int         BUFFER_DEPTH = 4,
  parameter logic [4:0] DIRECTION    = 5'b00001,
  parameter bit         ADAPTIVE     = 1'b1,
  parameter int         ADAPT_WAIT   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          si,
  input  logic [DATA_WIDTH-1:0]         datai,
  output logic                          ri,
  input  logic [4:0]                    gnt,
  output logic [4:0]                    req,
  output logic [DATA_WIDTH-1:0]         datao,
  output logic [$clog2(BUFFER_DEPTH):0] fifo_count
);
  localparam int           CW        = $clog2(BUFFER_DEPTH) + 1;
  localparam logic [CW-1:0] ONE_CNT  = 1;
  localparam logic [7:0]   WAIT_LAST = 8'(ADAPT_WAIT - 1);

  logic [DATA_WIDTH-1:0] head, nxt;
  logic [CW-1:0]         count;
  logic                  full, empty;
  logic                  push, pop, detour;
  logic [HOP_W-1:0]      head_yh;
  route_t                rt_head, rt_next, rt_detour;

  state_e                state_q, state_d;
  logic [4:0]            req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]            wait_q, wait_d;
  logic                  adapted_q, adapted_d;

  assign ri         = !full;
  assign push       = si && !full;
  assign pop        = (state_q == ST_REQ) && ((gnt & req_q) != 5'b0);
  assign req        = req_q;
  assign datao      = data_q;
  assign fifo_count = count;
  assign head_yh    = head[YH_LSB +: HOP_W];

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUFFER_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (datai),
    .head  (head),
    .next  (nxt),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A grant in the eligibility cycle takes priority, so detour is gated by !pop.
  assign detour = ADAPTIVE && (state_q == ST_REQ) && !pop && !adapted_q &&
                  (wait_q == WAIT_LAST) && ((req_q & (DIR_L | DIR_R)) != 5'b0) &&
                  (head_yh != '0);

  always_comb begin
    rt_head   = route_calc(head[HDR_W-1:0], 1'b0);
    rt_next   = route_calc(nxt[HDR_W-1:0], 1'b0);
    rt_detour = route_calc(head[HDR_W-1:0], 1'b1);
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    wait_d    = wait_q;
    adapted_d = adapted_q;
    case (state_q)
      ST_IDLE: begin
        req_d = 5'b0;
        if (!empty) begin
          state_d             = ST_REQ;
          req_d               = rt_head.dir;
          data_d              = head;
          data_d[HDR_W-1:0]   = rt_head.hdr;
          wait_d              = 8'd0;
          adapted_d           = 1'b0;
        end
      end
      ST_REQ: begin
        if (pop) begin
          wait_d    = 8'd0;
          adapted_d = 1'b0;
          if (count > ONE_CNT) begin
            req_d             = rt_next.dir;
            data_d            = nxt;
            data_d[HDR_W-1:0] = rt_next.hdr;
          end else begin
            state_d = ST_IDLE;
            req_d   = 5'b0;
          end
        end else if (detour) begin
          req_d             = rt_detour.dir;
          data_d            = head;
          data_d[HDR_W-1:0] = rt_detour.hdr;
          wait_d            = 8'd0;
          adapted_d         = 1'b1;
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 5'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 5'b0;
      wait_q    <= 8'd0;
      adapted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wait_q    <= wait_d;
      adapted_q <= adapted_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  a_no_uturn: assert property (@(posedge clk) disable iff (rst)
    (DIRECTION == DIR_PE) || ((req_q & DIRECTION) == 5'b0));

endmodule

// File: tb/tb_input_port_adaptive.sv
// Directed bench for input_port_adaptive: vector table for single-flit routing,
// plus hand sequences for back-pressure, detour, grant priority and async reset.
module tb_input_port_adaptive;

  logic        clk = 1'b0;
  logic        rst;
  logic        si, si2;
  logic [63:0] datai, datai2;
  logic        ri, ri2;
  logic [4:0]  gnt, gnt2;
  logic [4:0]  req, req2;
  logic [63:0] datao, datao2;
  logic [2:0]  fifo_count, fifo_count2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  input_port_adaptive #(
    .DATA_WIDTH(64), .HOP_W(8), .BUFFER_DEPTH(4), .DIRECTION(5'b00001),
    .ADAPTIVE(1'b1), .ADAPT_WAIT(4)
  ) dut (
    .clk(clk), .rst(rst), .si(si), .datai(datai), .ri(ri), .gnt(gnt),
    .req(req), .datao(datao), .fifo_count(fifo_count)
  );

  input_port_adaptive #(
    .DATA_WIDTH(64), .HOP_W(8), .BUFFER_DEPTH(4), .DIRECTION(5'b00001),
    .ADAPTIVE(1'b0), .ADAPT_WAIT(4)
  ) dut_na (
    .clk(clk), .rst(rst), .si(si2), .datai(datai2), .ri(ri2), .gnt(gnt2),
    .req(req2), .datao(datao2), .fifo_count(fifo_count2)
  );

  typedef struct packed {
    logic [63:0] flit;
    logic [4:0]  ereq;
    logic [63:0] edata;
  } vec_t;

  vec_t vt [6];

  function automatic logic [63:0] mk(input bit xs, input bit ys, input logic [7:0] xh,
                                     input logic [7:0] yh, input logic [15:0] tag);
    logic [63:0] f;
    f        = 64'h0;
    f[63:62] = 2'b10;
    f[61]    = xs;
    f[60]    = ys;
    f[59:56] = 4'h5;
    f[55:48] = xh;
    f[47:40] = yh;
    f[39:16] = 24'hC0FFEE;
    f[15:0]  = tag;
    return f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{mk(0,0,8'd2,8'd0,16'h1111),   5'b01000, mk(0,0,8'd1,8'd0,16'h1111)};
    vt[1] = '{mk(0,0,8'd0,8'd0,16'h2222),   5'b00001, mk(0,0,8'd0,8'd0,16'h2222)};
    vt[2] = '{mk(0,1,8'd0,8'd3,16'h3333),   5'b00010, mk(0,1,8'd0,8'd2,16'h3333)};
    vt[3] = '{mk(1,1,8'd5,8'd7,16'h4444),   5'b10000, mk(1,1,8'd4,8'd7,16'h4444)};
    vt[4] = '{mk(0,0,8'd0,8'd1,16'h5555),   5'b00100, mk(0,0,8'd0,8'd0,16'h5555)};
    vt[5] = '{mk(0,1,8'd255,8'd9,16'h6666), 5'b01000, mk(0,1,8'd254,8'd9,16'h6666)};

    rst = 1'b1; si = 1'b0; si2 = 1'b0; datai = '0; datai2 = '0; gnt = '0; gnt2 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_req", req, 5'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ri", ri, 1'b1);
    chk("rst_ri_na", ri2, 1'b1);

    // single-flit routing table
    for (int i = 0; i < 6; i++) begin
      si = 1'b1; datai = vt[i].flit;
      tick();
      si = 1'b0;
      chk($sformatf("v%0d_lat_req", i), req, 5'b0);
      chk($sformatf("v%0d_lat_cnt", i), fifo_count, 3'd1);
      tick();
      chk($sformatf("v%0d_req", i), req, vt[i].ereq);
      chk($sformatf("v%0d_datao", i), datao, vt[i].edata);
      gnt = vt[i].ereq;
      tick();
      gnt = 5'b0;
      chk($sformatf("v%0d_idle_req", i), req, 5'b0);
      chk($sformatf("v%0d_idle_cnt", i), fifo_count, 3'd0);
    end

    // grant bits outside req must not pop
    si = 1'b1; datai = mk(0,0,8'd1,8'd0,16'h7777);
    tick(); si = 1'b0;
    tick();
    gnt = 5'b10111;
    tick();
    chk("offgnt_req", req, 5'b01000);
    chk("offgnt_cnt", fifo_count, 3'd1);
    gnt = 5'b01000;
    tick(); gnt = 5'b0;
    chk("offgnt_pop_req", req, 5'b0);

    // push into an empty FIFO during the final pop still passes through IDLE
    si = 1'b1; datai = mk(0,0,8'd1,8'd0,16'h0A0A);
    tick(); si = 1'b0;
    tick();
    chk("pp_req0", req, 5'b01000);
    gnt = 5'b01000; si = 1'b1; datai = mk(1,0,8'd3,8'd0,16'h0B0B);
    tick(); gnt = 5'b0; si = 1'b0;
    chk("pp_idle_req", req, 5'b0);
    chk("pp_idle_cnt", fifo_count, 3'd1);
    tick();
    chk("pp_req1", req, 5'b10000);
    chk("pp_data1", datao, mk(1,0,8'd2,8'd0,16'h0B0B));
    gnt = 5'b10000;
    tick(); gnt = 5'b0;
    chk("pp_end_cnt", fifo_count, 3'd0);

    // fill to full, drop a fifth flit, then drain back-to-back
    si = 1'b1;
    datai = mk(0,0,8'd1,8'd0,16'hB001); tick();
    datai = mk(1,0,8'd1,8'd0,16'hB002); tick();
    datai = mk(0,0,8'd0,8'd1,16'hB003); tick();
    datai = mk(0,1,8'd0,8'd1,16'hB004); tick();
    chk("full_ri", ri, 1'b0);
    chk("full_cnt", fifo_count, 3'd4);
    datai = mk(0,0,8'd0,8'd0,16'hDEAD); tick();
    si = 1'b0;
    chk("drop_cnt", fifo_count, 3'd4);
    chk("drain_req0", req, 5'b01000);
    gnt = 5'b11111;
    tick();
    chk("drain_req1", req, 5'b10000);
    chk("drain_cnt1", fifo_count, 3'd3);
    tick();
    chk("drain_req2", req, 5'b00100);
    chk("drain_dat2", datao, mk(0,0,8'd0,8'd0,16'hB003));
    chk("drain_cnt2", fifo_count, 3'd2);
    tick();
    chk("drain_req3", req, 5'b00010);
    chk("drain_cnt3", fifo_count, 3'd1);
    tick();
    chk("drain_req4", req, 5'b0);
    chk("drain_cnt4", fifo_count, 3'd0);
    tick();
    chk("drain_stale_req", req, 5'b0);
    chk("drain_stale_cnt", fifo_count, 3'd0);
    gnt = 5'b0;

    // detour after four stalled cycles, only once
    si = 1'b1; datai = mk(1,1,8'd1,8'd2,16'h8888);
    tick(); si = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("adp_wait%0d_req", c), req, 5'b10000);
    end
    chk("adp_wait_data", datao, mk(1,1,8'd0,8'd2,16'h8888));
    tick();
    chk("adp_det_req", req, 5'b00010);
    chk("adp_det_data", datao, mk(1,1,8'd1,8'd1,16'h8888));
    repeat (10) tick();
    chk("adp_once_req", req, 5'b00010);
    chk("adp_once_data", datao, mk(1,1,8'd1,8'd1,16'h8888));
    gnt = 5'b00010;
    tick(); gnt = 5'b0;
    chk("adp_pop_req", req, 5'b0);
    chk("adp_pop_cnt", fifo_count, 3'd0);

    // grant in the eligibility cycle wins over detour
    si = 1'b1; datai = mk(1,1,8'd1,8'd2,16'h9999);
    tick(); si = 1'b0;
    repeat (4) tick();
    chk("race_req", req, 5'b10000);
    gnt = 5'b10000;
    tick(); gnt = 5'b0;
    chk("race_pop_req", req, 5'b0);
    chk("race_pop_cnt", fifo_count, 3'd0);

    // non-adaptive instance never detours
    si2 = 1'b1; datai2 = mk(1,1,8'd1,8'd2,16'hAAAA);
    tick(); si2 = 1'b0;
    repeat (20) tick();
    chk("na_req", req2, 5'b10000);
    chk("na_data", datao2, mk(1,1,8'd0,8'd2,16'hAAAA));
    gnt2 = 5'b10000;
    tick(); gnt2 = 5'b0;
    chk("na_pop_req", req2, 5'b0);

    // asynchronous reset with three flits queued
    si = 1'b1;
    datai = mk(0,0,8'd1,8'd0,16'hC001); tick();
    datai = mk(0,0,8'd1,8'd0,16'hC002); tick();
    datai = mk(0,0,8'd1,8'd0,16'hC003); tick();
    si = 1'b0;
    chk("prerst_cnt", fifo_count, 3'd3);
    chk("prerst_req", req, 5'b01000);
    #3 rst = 1'b1;
    #1;
    chk("async_req", req, 5'b0);
    chk("async_cnt", fifo_count, 3'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("postrst_ri", ri, 1'b1);
    chk("postrst_req", req, 5'b0);
    tick();
    chk("postrst_req2", req, 5'b0);
    chk("postrst_cnt", fifo_count, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
